seg_mux_scheduler: RTL and testbench

SEG_MUX_SCHEDULER -- requirements
Module: seg_mux_scheduler

---
 rtl/seg_mux_scheduler.sv | 74 +++++++
 tb/tb_seg_mux_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_mux_scheduler.sv
// rtl/seg_mux_scheduler.sv - two-digit seven-segment time-share scheduler with blanking and frame shadows
module seg_mux_scheduler #(
  parameter int HOLD_CYCLES  = 2400,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic [1:0] en,
  output logic [3:0] s,
  output logic [1:0] an,
  output logic       digit,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  localparam logic [11:0] HOLD_LAST  = 12'(HOLD_CYCLES - 1);
  localparam logic [11:0] BLANK_LAST = 12'(BLANK_CYCLES - 1);

  state_t      state;
  logic [11:0] cnt;
  logic [3:0]  sh0;
  logic [3:0]  sh1;
  logic        dwell_last;

  // state[0] marks the SHOW states, state[1] the digit being served
  assign dwell_last = state[0] ? (cnt == HOLD_LAST) : (cnt == BLANK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK0;
      cnt        <= 12'd0;
      sh0        <= 4'h0;
      sh1        <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (dwell_last) begin
        cnt <= 12'd0;
        case (state)
          BLANK0: state <= SHOW0;
          SHOW0:  state <= BLANK1;
          BLANK1: state <= SHOW1;
          SHOW1: begin
            state      <= BLANK0;
            sh0        <= s0;
            sh1        <= s1;
            frame_done <= 1'b1;
          end
        endcase
      end else begin
        cnt <= cnt + 12'd1;
      end
    end
  end

  // Decoded straight from state so the decoder nibble only moves as a blank begins
  assign digit = state[1];
  assign s     = state[1] ? sh1 : sh0;

  always_comb begin
    an = 2'b11;
    if (state == SHOW0) an[0] = ~en[0];
    if (state == SHOW1) an[1] = ~en[1];
  end

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// tb/tb_seg_mux_scheduler.sv - directed and randomized checks of seg_mux_scheduler
module tb_seg_mux_scheduler;

  localparam int FRAME = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset_f;
  logic [3:0] s0;
  logic [3:0] s1;
  logic [1:0] en;
  logic [3:0] s;
  logic [1:0] an;
  logic       digit;
  logic       frame_done;
  logic [3:0] f_s;
  logic [1:0] f_an;
  logic       f_digit;
  logic       f_fd;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int         ph;
  logic       fresh;
  logic [3:0] m_sh0;
  logic [3:0] m_sh1;
  logic [3:0] prev_s;

  always #5 clk = ~clk;

  seg_mux_scheduler #(.HOLD_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .s0(s0), .s1(s1), .en(en),
    .s(s), .an(an), .digit(digit), .frame_done(frame_done)
  );

  seg_mux_scheduler #(.HOLD_CYCLES(1), .BLANK_CYCLES(1)) dut_fast (
    .clk(clk), .reset(reset_f), .s0(s0), .s1(s1), .en(en),
    .s(f_s), .an(f_an), .digit(f_digit), .frame_done(f_fd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag);
    logic [1:0] ea;
    logic [3:0] es;
    logic       ed;
    logic       efd;
    ed  = (ph >= 6);
    es  = ed ? m_sh1 : m_sh0;
    ea  = 2'b11;
    if (ph >= 2 && ph < 6) ea[0] = ~en[0];
    if (ph >= 8)           ea[1] = ~en[1];
    efd = (ph == 0) && !fresh;
    chk({tag, ".an"}, 32'(an), 32'(ea));
    chk({tag, ".s"}, 32'(s), 32'(es));
    chk({tag, ".digit"}, 32'(digit), 32'(ed));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(efd));
    chk({tag, ".an_not_00"}, 32'(an == 2'b00), 32'd0);
  endtask

  task automatic advance();
    if (ph == FRAME - 1) begin
      m_sh0 = s0;
      m_sh1 = s1;
    end
    ph    = (ph + 1) % FRAME;
    fresh = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    ph    = 0;
    fresh = 1'b1;
    m_sh0 = 4'h0;
    m_sh1 = 4'h0;
  endtask

  initial begin
    reset   = 1'b1;
    reset_f = 1'b1;
    s0      = 4'h5;
    s1      = 4'hA;
    en      = 2'b11;
    #1;
    chk("rst.an", 32'(an), 32'h3);
    chk("rst.s", 32'(s), 32'h0);
    chk("rst.digit", 32'(digit), 32'h0);
    chk("rst.frame_done", 32'(frame_done), 32'h0);
    chk("rst_fast.an", 32'(f_an), 32'h3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Base sequence, with s0 changed mid-frame in frame 1
    for (int k = 0; k < 36; k++) begin
      check_cycle($sformatf("base%0d", k));
      if (k == 0)  begin chk("c0.an", 32'(an), 32'h3); chk("c0.s", 32'(s), 32'h0); end
      if (k == 2)  begin chk("c2.an", 32'(an), 32'h2); chk("c2.s", 32'(s), 32'h0); end
      if (k == 8)  begin chk("c8.an", 32'(an), 32'h1); chk("c8.digit", 32'(digit), 32'h1); end
      if (k == 12) begin
        chk("c12.fd", 32'(frame_done), 32'h1);
        chk("c12.s", 32'(s), 32'h5);
        chk("c12.an", 32'(an), 32'h3);
      end
      if (k == 14) begin chk("c14.an", 32'(an), 32'h2); chk("c14.s", 32'(s), 32'h5); end
      if (k == 17) chk("c17.s", 32'(s), 32'h5);
      if (k == 20) begin chk("c20.an", 32'(an), 32'h1); chk("c20.s", 32'(s), 32'hA); end
      if (k == 24) chk("c24.s", 32'(s), 32'h3);
      if (k == 15) s0 = 4'h3;
      advance();
    end

    // Per-digit enables: one frame en=01, two frames en=00
    en = 2'b01;
    for (int k = 0; k < 36; k++) begin
      if (k == 12) en = 2'b00;
      check_cycle($sformatf("en%0d", k));
      chk($sformatf("en%0d.an1", k), 32'(an[1]), 32'h1);
      if (k >= 12) chk($sformatf("en%0d.dark", k), 32'(an), 32'h3);
      if (k == 12 || k == 24) chk($sformatf("en%0d.fd", k), 32'(frame_done), 32'h1);
      advance();
    end

    // Reset asserted between edges during SHOW1
    en = 2'b11;
    for (int k = 0; k < 9; k++) begin
      check_cycle($sformatf("pre%0d", k));
      advance();
    end
    check_cycle("pre9");
    #1 reset = 1'b1;
    #1;
    chk("mid_rst.an", 32'(an), 32'h3);
    chk("mid_rst.s", 32'(s), 32'h0);
    chk("mid_rst.digit", 32'(digit), 32'h0);
    chk("mid_rst.fd", 32'(frame_done), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 24; k++) begin
      check_cycle($sformatf("post%0d", k));
      if (k == 2)  chk("post2.s", 32'(s), 32'h0);
      if (k == 12) chk("post12.s", 32'(s), 32'h3);
      if (k == 20) chk("post20.s", 32'(s), 32'hA);
      advance();
    end

    // Random inputs
    prev_s = s;
    for (int k = 0; k < 2000; k++) begin
      check_cycle($sformatf("rnd%0d", k));
      if (ph != 0 && ph != 6) chk($sformatf("rnd%0d.s_stable", k), 32'(s), 32'(prev_s));
      prev_s = s;
      s0 = 4'($urandom);
      s1 = 4'($urandom);
      en = 2'($urandom_range(0, 3));
      advance();
    end

    // One-cycle dwell instance
    s0 = 4'h7;
    s1 = 4'hC;
    en = 2'b11;
    reset_f = 1'b0;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] ea;
      logic [3:0] es;
      int p4;
      p4 = k % 4;
      ea = (p4 == 1) ? 2'b10 : (p4 == 3) ? 2'b01 : 2'b11;
      es = (k < 4) ? 4'h0 : (p4 < 2) ? 4'h7 : 4'hC;
      chk($sformatf("fast%0d.an", k), 32'(f_an), 32'(ea));
      chk($sformatf("fast%0d.digit", k), 32'(f_digit), 32'(p4 >= 2));
      chk($sformatf("fast%0d.fd", k), 32'(f_fd), 32'(p4 == 0 && k > 0));
      chk($sformatf("fast%0d.s", k), 32'(f_s), 32'(es));
      @(posedge clk);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
